// File: rtl/tau_pkg.sv
`default_nettype none
// ============================================================================
// Module      : tau_pkg
// Description : Shared types and helpers for the temporal-unary GEMM drain.
// Revision    : 1.0 - initial release
// ============================================================================
package tau_pkg;

  // Drain-stage controller states
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_DRAIN = 2'd2
  } drain_state_t;

  // Four guard bits allow up to 16 full-scale tiles before wrapping
  function automatic int default_acc_bits(input int out_bits);
    return out_bits + 4;
  endfunction

endpackage
`default_nettype wire

// File: rtl/tau_acc_cell.sv
`default_nettype none
// ============================================================================
// Module      : tau_acc_cell
// Description : One accumulator element. Load captures the first tile, add
//               accumulates subsequent tiles. Optional saturation via the
//               TAU_DRAIN_SAT_EN macro (default build wraps).
// Revision    : 1.0 - initial release
// ============================================================================
module tau_acc_cell #(
  parameter int OUT_BITS = 16,
  parameter int ACC_BITS = 20
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                load,
  input  logic                add,
  input  logic [OUT_BITS-1:0] din,
  output logic [ACC_BITS-1:0] acc
);

  logic [ACC_BITS-1:0] sum;

`ifdef TAU_DRAIN_SAT_EN
  // One extra bit catches the carry; a carry clamps to all-ones, and since
  // inputs are unsigned a clamped element can never fall back below max.
  logic [ACC_BITS:0] sum_wide;
  assign sum_wide = {1'b0, acc} + (ACC_BITS+1)'(din);
  assign sum      = sum_wide[ACC_BITS] ? {ACC_BITS{1'b1}} : sum_wide[ACC_BITS-1:0];
`else
  assign sum = acc + ACC_BITS'(din);
`endif

  // Element register: load takes priority, otherwise accumulate on add
  always_ff @(posedge clk) begin
    if (reset) begin
      acc <= '0;
    end else if (load) begin
      acc <= ACC_BITS'(din);
    end else if (add) begin
      acc <= sum;
    end
  end

endmodule
`default_nettype wire

// File: rtl/tau_gemm_drain.sv
`default_nettype none
// ============================================================================
// Module      : tau_gemm_drain
// Description : Captures the DIMxDIM GEMM result on gemm_finished, optionally
//               accumulates num_tiles K-tiles, then streams one accumulator
//               row per beat over valid/ready. Saturating accumulate is
//               enabled by defining TAU_DRAIN_SAT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tau_gemm_drain
  import tau_pkg::*;
#(
  parameter int DIM      = 16,
  parameter int BITWIDTH = 8,
  parameter int OUT_BITS = 2*BITWIDTH,
  parameter int ACC_BITS = default_acc_bits(OUT_BITS),
  parameter int TILE_W   = 4
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [TILE_W-1:0]           num_tiles,
  input  logic [DIM*DIM*OUT_BITS-1:0] gemm_out,
  input  logic                        gemm_finished,
  output logic                        gemm_ready,
  output logic                        row_valid,
  input  logic                        row_ready,
  output logic [DIM*ACC_BITS-1:0]     row_data,
  output logic [$clog2(DIM)-1:0]      row_idx,
  output logic                        row_last,
  output logic                        overflow_err
);

  localparam int PTR_W = $clog2(DIM);

  localparam logic [1:0] S_IDLE  = ST_IDLE;
  localparam logic [1:0] S_ACCUM = ST_ACCUM;
  localparam logic [1:0] S_DRAIN = ST_DRAIN;

  logic [1:0]              state;
  logic [1:0]              state_nxt;
  logic [TILE_W-1:0]       tile_cnt;
  logic [TILE_W-1:0]       tiles_q;
  logic [TILE_W-1:0]       tiles_in;
  logic [TILE_W-1:0]       cnt_inc;
  logic [PTR_W-1:0]        row_ptr;
  logic                    overflow_q;
  logic                    load;
  logic                    add;
  logic                    row_at_last;
  logic                    handshake;
  logic [DIM*DIM*ACC_BITS-1:0] acc_flat;

  assign tiles_in    = (num_tiles == '0) ? TILE_W'(1) : num_tiles;
  assign cnt_inc     = tile_cnt + TILE_W'(1);
  assign row_at_last = (row_ptr == PTR_W'(DIM-1));

  // Ready and valid depend only on the registered state
  assign gemm_ready   = (state != S_DRAIN);
  assign row_valid    = (state == S_DRAIN);
  assign handshake    = row_valid & row_ready;
  assign row_idx      = row_ptr;
  assign row_last     = row_valid & row_at_last;
  assign overflow_err = overflow_q;
  assign row_data     = acc_flat[int'(row_ptr)*DIM*ACC_BITS +: DIM*ACC_BITS];

  // Next-state and accumulator-control decode
  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    add       = 1'b0;
    case (state)
      S_IDLE: begin
        if (gemm_finished) begin
          load      = 1'b1;
          state_nxt = (tiles_in == TILE_W'(1)) ? S_DRAIN : S_ACCUM;
        end
      end
      S_ACCUM: begin
        if (gemm_finished) begin
          add = 1'b1;
          if (cnt_inc == tiles_q) state_nxt = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (handshake && row_at_last) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // State, tile counter, row pointer and sticky drop flag
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      tile_cnt   <= '0;
      tiles_q    <= '0;
      row_ptr    <= '0;
      overflow_q <= 1'b0;
    end else begin
      state <= state_nxt;
      if (load) begin
        tile_cnt <= TILE_W'(1);
        tiles_q  <= tiles_in;
      end else if (add) begin
        tile_cnt <= cnt_inc;
      end
      if (handshake) begin
        row_ptr <= row_at_last ? '0 : row_ptr + PTR_W'(1);
      end
      if (gemm_finished && !gemm_ready) begin
        overflow_q <= 1'b1;
      end
    end
  end

  for (genvar i = 0; i < DIM; i++) begin : g_row
    for (genvar j = 0; j < DIM; j++) begin : g_col
      tau_acc_cell #(
        .OUT_BITS (OUT_BITS),
        .ACC_BITS (ACC_BITS)
      ) u_cell (
        .clk   (clk),
        .reset (reset),
        .load  (load),
        .add   (add),
        .din   (gemm_out[(i*DIM+j)*OUT_BITS +: OUT_BITS]),
        .acc   (acc_flat[(i*DIM+j)*ACC_BITS +: ACC_BITS])
      );
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_tau_gemm_drain.sv
`default_nettype none
// ============================================================================
// Module      : tb_tau_gemm_drain
// Description : Self-checking bench for tau_gemm_drain (DIM=4, ACC_BITS=17)
//               with a sum-then-wrap/clamp reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_tau_gemm_drain;

  localparam int DIM = 4;
  localparam int BW  = 8;
  localparam int OB  = 16;
  localparam int AB  = 17;
  localparam int TW  = 4;
  localparam int PW  = $clog2(DIM);
  localparam longint ACC_MAX = (longint'(1) << AB) - 1;

  logic                   clk = 1'b0;
  logic                   reset;
  logic [TW-1:0]          num_tiles;
  logic [DIM*DIM*OB-1:0]  gemm_out;
  logic                   gemm_finished;
  logic                   gemm_ready;
  logic                   row_valid;
  logic                   row_ready;
  logic [DIM*AB-1:0]      row_data;
  logic [PW-1:0]          row_idx;
  logic                   row_last;
  logic                   overflow_err;

  int checks = 0;
  int errors = 0;

  // Reference model: exact integer sums of every tile in the job
  longint        tot [DIM][DIM];
  logic [OB-1:0] tile_m [DIM][DIM];

  // Collector results
  logic [DIM*AB-1:0] got_data [DIM];
  logic [PW-1:0]     got_idx  [DIM];
  logic              got_last [DIM];
  int                hs_cyc   [DIM];
  int                n_got;
  int                first_wait;
  logic              hold_bad;

  tau_gemm_drain #(
    .DIM      (DIM),
    .BITWIDTH (BW),
    .OUT_BITS (OB),
    .ACC_BITS (AB),
    .TILE_W   (TW)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .num_tiles     (num_tiles),
    .gemm_out      (gemm_out),
    .gemm_finished (gemm_finished),
    .gemm_ready    (gemm_ready),
    .row_valid     (row_valid),
    .row_ready     (row_ready),
    .row_data      (row_data),
    .row_idx       (row_idx),
    .row_last      (row_last),
    .overflow_err  (overflow_err)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [AB-1:0] exp_el(int i, int j);
`ifdef TAU_DRAIN_SAT_EN
    if (tot[i][j] > ACC_MAX) return AB'(ACC_MAX);
`endif
    return AB'(tot[i][j]);
  endfunction

  function automatic logic [DIM*AB-1:0] exp_row(int i);
    logic [DIM*AB-1:0] r;
    for (int j = 0; j < DIM; j++) r[j*AB +: AB] = exp_el(i, j);
    return r;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < DIM; i++)
      for (int j = 0; j < DIM; j++) tot[i][j] = 0;
  endtask

  task automatic fill_const(input logic [OB-1:0] v);
    for (int i = 0; i < DIM; i++)
      for (int j = 0; j < DIM; j++) tile_m[i][j] = v;
  endtask

  task automatic fill_rand();
    for (int i = 0; i < DIM; i++)
      for (int j = 0; j < DIM; j++) tile_m[i][j] = OB'($urandom);
  endtask

  // Present tile_m for one cycle and add it to the model
  task automatic send_tile();
    for (int i = 0; i < DIM; i++)
      for (int j = 0; j < DIM; j++) begin
        gemm_out[(i*DIM+j)*OB +: OB] = tile_m[i][j];
        tot[i][j] += longint'(tile_m[i][j]);
      end
    gemm_finished = 1'b1;
    step();
    gemm_finished = 1'b0;
  endtask

  // Accept rows, optionally stalling one row and injecting a stray pulse
  task automatic collect(input int stall_row, input int stall_cycles, input int pulse_row);
    int cyc = 0;
    int stalls = 0;
    logic [DIM*AB-1:0] snap = '0;
    n_got = 0; first_wait = -1; hold_bad = 1'b0;
    while (n_got < DIM && cyc < 200) begin
      gemm_finished = 1'b0;
      if (row_valid && first_wait < 0) first_wait = cyc;
      if (row_valid && int'(row_idx) == stall_row && stalls < stall_cycles) begin
        if (stalls == 0) snap = row_data;
        else if (row_data !== snap) hold_bad = 1'b1;
        row_ready = 1'b0;
        stalls++;
      end else begin
        if (stalls > 0 && n_got <= stall_row && (!row_valid || row_data !== snap)) hold_bad = 1'b1;
        row_ready = 1'b1;
      end
      if (row_valid && row_ready) begin
        got_data[n_got] = row_data;
        got_idx[n_got]  = row_idx;
        got_last[n_got] = row_last;
        hs_cyc[n_got]   = cyc;
        n_got++;
        if (int'(row_idx) == pulse_row) begin
          gemm_finished = 1'b1;
          for (int k = 0; k < DIM*DIM; k++) gemm_out[k*OB +: OB] = OB'($urandom);
        end
      end
      step();
      cyc++;
    end
    gemm_finished = 1'b0;
    row_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) step();
    checks++; if (gemm_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", gemm_ready); end
    checks++; if (row_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", row_valid); end
    checks++; if (row_idx !== '0) begin errors++; $display("FAIL reset_idx: got %0d want 0", row_idx); end
    checks++; if (row_last !== 1'b0) begin errors++; $display("FAIL reset_last: got %b want 0", row_last); end
    checks++; if (overflow_err !== 1'b0) begin errors++; $display("FAIL reset_ovf: got %b want 0", overflow_err); end
    reset = 1'b0;
    step();
  endtask

  task automatic test_single_tile();
    num_tiles = 4'd1;
    model_clear();
    for (int i = 0; i < DIM; i++)
      for (int j = 0; j < DIM; j++) tile_m[i][j] = OB'(4*i + j);
    send_tile();
    collect(-1, 0, -1);
    checks++; if (first_wait !== 0) begin errors++; $display("FAIL single_latency: got %0d want 0", first_wait); end
    checks++; if (n_got !== DIM) begin errors++; $display("FAIL single_rows: got %0d want %0d", n_got, DIM); end
    for (int r = 0; r < n_got; r++) begin
      checks++; if (int'(got_idx[r]) !== r) begin errors++; $display("FAIL single_idx: got %0d want %0d", got_idx[r], r); end
      checks++; if (got_last[r] !== (r == DIM-1)) begin errors++; $display("FAIL single_last row %0d: got %b", r, got_last[r]); end
      checks++; if (hs_cyc[r] !== r) begin errors++; $display("FAIL single_cycle row %0d: got %0d want %0d", r, hs_cyc[r], r); end
      checks++; if (got_data[r] !== exp_row(r)) begin errors++; $display("FAIL single_data row %0d: got %h want %h", r, got_data[r], exp_row(r)); end
    end
    checks++; if (got_data[2][2*AB +: AB] !== 17'd10) begin errors++; $display("FAIL single_row2: got %0d want 10", got_data[2][2*AB +: AB]); end
    checks++; if (row_valid !== 1'b0 || gemm_ready !== 1'b1) begin errors++; $display("FAIL single_idle: got valid %b ready %b want 0 1", row_valid, gemm_ready); end
  endtask

  task automatic test_multi_tile();
    num_tiles = 4'd3;
    model_clear();
    fill_const(16'h0100);
    for (int t = 0; t < 3; t++) begin
      send_tile();
      if (t == 0) num_tiles = 4'd1;
      if (t < 2) begin
        step();
        checks++; if (gemm_ready !== 1'b1 || row_valid !== 1'b0) begin errors++; $display("FAIL multi_between %0d: got ready %b valid %b want 1 0", t, gemm_ready, row_valid); end
      end
    end
    collect(-1, 0, -1);
    checks++; if (n_got !== DIM || first_wait !== 0) begin errors++; $display("FAIL multi_rows: got %0d wait %0d want %0d 0", n_got, first_wait, DIM); end
    for (int r = 0; r < n_got; r++) begin
      checks++; if (got_data[r] !== {DIM{17'h00300}}) begin errors++; $display("FAIL multi_data row %0d: got %h want all 0x300", r, got_data[r]); end
    end
    checks++; if (row_valid !== 1'b0) begin errors++; $display("FAIL multi_single_drain: got valid %b want 0", row_valid); end
  endtask

  task automatic test_wrap_sat();
    num_tiles = 4'd2;
    model_clear();
    fill_const(16'hFFFF);
    repeat (2) send_tile();
    collect(-1, 0, -1);
    checks++; if (got_data[0][0 +: AB] !== 17'h1FFFE) begin errors++; $display("FAIL two_ffff: got %h want 1fffe", got_data[0][0 +: AB]); end
    num_tiles = 4'd3;
    model_clear();
    repeat (3) send_tile();
    collect(-1, 0, -1);
`ifdef TAU_DRAIN_SAT_EN
    checks++; if (got_data[3][3*AB +: AB] !== 17'h1FFFF) begin errors++; $display("FAIL three_ffff: got %h want 1ffff", got_data[3][3*AB +: AB]); end
`else
    checks++; if (got_data[3][3*AB +: AB] !== 17'h0FFFD) begin errors++; $display("FAIL three_ffff: got %h want 0fffd", got_data[3][3*AB +: AB]); end
`endif
    checks++; if (got_data[1] !== exp_row(1)) begin errors++; $display("FAIL three_model: got %h want %h", got_data[1], exp_row(1)); end
  endtask

  task automatic test_backpressure();
    num_tiles = 4'd1;
    model_clear();
    fill_rand();
    send_tile();
    collect(1, 5, -1);
    checks++; if (hold_bad !== 1'b0) begin errors++; $display("FAIL bp_hold: got %b want 0", hold_bad); end
    checks++; if (n_got !== DIM) begin errors++; $display("FAIL bp_rows: got %0d want %0d", n_got, DIM); end
    for (int r = 0; r < n_got; r++) begin
      checks++; if (int'(got_idx[r]) !== r || got_data[r] !== exp_row(r)) begin errors++; $display("FAIL bp_row %0d: got idx %0d data %h want %h", r, got_idx[r], got_data[r], exp_row(r)); end
    end
    checks++; if (hs_cyc[2] !== 7) begin errors++; $display("FAIL bp_timing: got %0d want 7", hs_cyc[2]); end
  endtask

  task automatic test_overflow();
    checks++; if (overflow_err !== 1'b0) begin errors++; $display("FAIL ovf_pre: got %b want 0", overflow_err); end
    num_tiles = 4'd1;
    model_clear();
    fill_rand();
    send_tile();
    collect(-1, 0, 1);
    checks++; if (overflow_err !== 1'b1) begin errors++; $display("FAIL ovf_mid: got %b want 1", overflow_err); end
    for (int r = 0; r < DIM; r++) begin
      checks++; if (got_data[r] !== exp_row(r)) begin errors++; $display("FAIL ovf_mid_data row %0d: got %h want %h", r, got_data[r], exp_row(r)); end
    end
    reset = 1'b1; step(); reset = 1'b0; step();
    checks++; if (overflow_err !== 1'b0) begin errors++; $display("FAIL ovf_cleared: got %b want 0", overflow_err); end
    model_clear();
    fill_rand();
    send_tile();
    collect(-1, 0, DIM-1);
    checks++; if (overflow_err !== 1'b1) begin errors++; $display("FAIL ovf_last: got %b want 1", overflow_err); end
    checks++; if (row_valid !== 1'b0 || gemm_ready !== 1'b1) begin errors++; $display("FAIL ovf_last_idle: got valid %b ready %b want 0 1", row_valid, gemm_ready); end
    checks++; if (got_data[DIM-1] !== exp_row(DIM-1)) begin errors++; $display("FAIL ovf_last_data: got %h want %h", got_data[DIM-1], exp_row(DIM-1)); end
    repeat (3) step();
    checks++; if (overflow_err !== 1'b1 || row_valid !== 1'b0) begin errors++; $display("FAIL ovf_sticky: got ovf %b valid %b want 1 0", overflow_err, row_valid); end
  endtask

  task automatic test_reset_mid();
    // Abort during ACCUM
    num_tiles = 4'd3;
    model_clear();
    fill_rand();
    send_tile();
    reset = 1'b1; step();
    checks++; if (gemm_ready !== 1'b1 || row_valid !== 1'b0 || row_last !== 1'b0 || overflow_err !== 1'b0 || row_idx !== '0) begin
      errors++; $display("FAIL rst_accum: got ready %b valid %b last %b ovf %b idx %0d", gemm_ready, row_valid, row_last, overflow_err, row_idx); end
    reset = 1'b0; step();
    num_tiles = 4'd1;
    model_clear();
    fill_rand();
    send_tile();
    collect(-1, 0, -1);
    checks++; if (n_got !== DIM) begin errors++; $display("FAIL rst_new_rows: got %0d want %0d", n_got, DIM); end
    for (int r = 0; r < DIM; r++) begin
      checks++; if (got_data[r] !== exp_row(r)) begin errors++; $display("FAIL rst_new_data row %0d: got %h want %h", r, got_data[r], exp_row(r)); end
    end
    // Abort during DRAIN with the pointer on row 1
    model_clear();
    fill_rand();
    send_tile();
    row_ready = 1'b1; step(); row_ready = 1'b0; step();
    checks++; if (row_idx !== PW'(1) || row_valid !== 1'b1) begin errors++; $display("FAIL rst_pre_drain: got idx %0d valid %b want 1 1", row_idx, row_valid); end
    reset = 1'b1; step(); reset = 1'b0;
    checks++; if (row_idx !== '0 || row_valid !== 1'b0 || gemm_ready !== 1'b1) begin errors++; $display("FAIL rst_drain: got idx %0d valid %b ready %b want 0 0 1", row_idx, row_valid, gemm_ready); end
    step();
  endtask

  task automatic test_random();
    for (int job = 0; job < 8; job++) begin
      int nt = int'($urandom_range(0, 3));
      int eff = (nt == 0) ? 1 : nt;
      num_tiles = TW'(nt);
      model_clear();
      for (int t = 0; t < eff; t++) begin
        fill_rand();
        send_tile();
        num_tiles = TW'($urandom);
        if (t < eff-1) begin
          repeat ($urandom_range(0, 2)) step();
          checks++; if (row_valid !== 1'b0) begin errors++; $display("FAIL rand_early job %0d: got valid %b want 0", job, row_valid); end
        end
      end
      collect(int'($urandom_range(0, DIM-1)), int'($urandom_range(0, 3)), -1);
      checks++; if (n_got !== DIM || hold_bad !== 1'b0) begin errors++; $display("FAIL rand_rows job %0d: got %0d hold %b", job, n_got, hold_bad); end
      for (int r = 0; r < n_got; r++) begin
        checks++; if (int'(got_idx[r]) !== r || got_data[r] !== exp_row(r)) begin errors++; $display("FAIL rand_data job %0d row %0d: got %h want %h", job, r, got_data[r], exp_row(r)); end
      end
    end
  endtask

  initial begin
    reset = 1'b1;
    num_tiles = '0;
    gemm_out = '0;
    gemm_finished = 1'b0;
    row_ready = 1'b0;
    test_reset();
    test_single_tile();
    test_multi_tile();
    test_wrap_sat();
    test_backpressure();
    test_overflow();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
